// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
//   op_t    : 2-bit opcode (subtract, unsigned less-than, bit-set, SM->U2)
//   state_t : scheduler FSM states
//   ST_*    : 2-bit result status codes
//   rr_pick : round-robin winner between two requesters
package alu_sched_pkg;

    typedef enum logic [1:0] {
        OP_SUB  = 2'b00,
        OP_LT   = 2'b01,
        OP_SETB = 2'b10,
        OP_CONV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_NEG  = 2'b01;
    localparam logic [1:0] ST_EVEN = 2'b10;
    localparam logic [1:0] ST_ONES = 2'b11;

    // Winner index for a two-bit request vector. On a tie the requester that
    // was not granted last wins; a lone request wins regardless of last_gnt.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_gnt);
        logic pick;
        if (req == 2'b11) begin
            pick = ~last_gnt;
        end else begin
            pick = req[1];
        end
        return pick;
    endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Request/response bundle between two command sources and the scheduler.
//   i_req[1:0]                : request per requester (bit k = requester k)
//   i_op0/i_op1               : opcode per requester
//   i_argA0/i_argB0/i_argA1/i_argB1 : operands per requester
//   o_ack[1:0]                : one-cycle capture pulse
//   o_valid[1:0]              : one-cycle result pulse
//   o_result/o_status         : last result and status, held between responses
//   o_busy                    : scheduler not idle
// master = command-source side, slave = scheduler side.
interface alu_op_scheduler_if #(parameter int m = 4);
    import alu_sched_pkg::*;

    logic [1:0]   i_req;
    op_t          i_op0;
    op_t          i_op1;
    logic [m-1:0] i_argA0;
    logic [m-1:0] i_argB0;
    logic [m-1:0] i_argA1;
    logic [m-1:0] i_argB1;
    logic [1:0]   o_ack;
    logic [1:0]   o_valid;
    logic [m-1:0] o_result;
    logic [1:0]   o_status;
    logic         o_busy;

    modport master (
        output i_req, i_op0, i_op1, i_argA0, i_argB0, i_argA1, i_argB1,
        input  o_ack, o_valid, o_result, o_status, o_busy
    );

    modport slave (
        input  i_req, i_op0, i_op1, i_argA0, i_argB0, i_argA1, i_argB1,
        output o_ack, o_valid, o_result, o_status, o_busy
    );

endinterface

// File: rtl/alu_op_scheduler_alu_core.sv
// Purely combinational ALU datapath shared by both requesters.
//   i_op     : opcode
//   i_argA   : operand A (sign-magnitude for OP_CONV)
//   i_argB   : operand B (ignored by OP_CONV)
//   o_result : m-bit result
//   o_status : status of o_result (all-ones > even parity > MSB set > none)
module alu_core
    import alu_sched_pkg::*;
#(
    parameter int m = 4
) (
    input  op_t          i_op,
    input  logic [m-1:0] i_argA,
    input  logic [m-1:0] i_argB,
    output logic [m-1:0] o_result,
    output logic [1:0]   o_status
);

    logic [m-1:0] mag_ext;
    logic [m-1:0] res;

    // Magnitude of a sign-magnitude operand with the sign bit cleared.
    assign mag_ext = {1'b0, i_argA[m-2:0]};

    always_comb begin
        res = '0;
        case (i_op)
            OP_SUB:  res = i_argA - i_argB;
            OP_LT:   res = {{(m-1){1'b0}}, (i_argA < i_argB)};
            OP_SETB: res = i_argA | i_argB;
            // Two's-complement negate of the magnitude; negative zero wraps to 0.
            OP_CONV: res = i_argA[m-1] ? (~mag_ext + m'(1)) : i_argA;
            default: res = '0;
        endcase
    end

    always_comb begin
        if (&res) begin
            o_status = ST_ONES;
        end else if (~^res) begin
            o_status = ST_EVEN;
        end else if (res[m-1]) begin
            o_status = ST_NEG;
        end else begin
            o_status = ST_NONE;
        end
    end

    assign o_result = res;

endmodule

// File: rtl/alu_op_scheduler.sv
// Round-robin sequencer sharing one alu_core between two requesters.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : slave side of alu_op_scheduler_if (requests in, ack/valid/result out)
// Flow: IDLE captures the winning request (o_ack pulses during EXEC), EXEC
// registers the ALU output, RESP pulses o_valid, then back to IDLE.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int m = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    alu_op_scheduler_if.slave   bus
);

    state_t       state_q, state_d;
    logic         last_gnt_q, last_gnt_d;
    logic         gnt_q, gnt_d;
    op_t          op_q, op_d;
    logic [m-1:0] a_q, a_d;
    logic [m-1:0] b_q, b_d;
    logic [m-1:0] result_q, result_d;
    logic [1:0]   status_q, status_d;
    logic [1:0]   ack_q, ack_d;
    logic [1:0]   valid_q, valid_d;

    logic         win;
    logic [m-1:0] alu_result;
    logic [1:0]   alu_status;

    assign win = rr_pick(bus.i_req, last_gnt_q);

    alu_core #(.m(m)) u_alu_core (
        .i_op     (op_q),
        .i_argA   (a_q),
        .i_argB   (b_q),
        .o_result (alu_result),
        .o_status (alu_status)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        status_d   = status_q;
        ack_d      = '0;
        valid_d    = '0;
        case (state_q)
            IDLE: begin
                if (|bus.i_req) begin
                    state_d    = EXEC;
                    gnt_d      = win;
                    last_gnt_d = win;
                    op_d       = win ? bus.i_op1   : bus.i_op0;
                    a_d        = win ? bus.i_argA1 : bus.i_argA0;
                    b_d        = win ? bus.i_argB1 : bus.i_argB0;
                    ack_d[win] = 1'b1;
                end
            end
            EXEC: begin
                result_d       = alu_result;
                status_d       = alu_status;
                valid_d[gnt_q] = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;  // requester 0 wins the first tie
            gnt_q      <= 1'b0;
            op_q       <= OP_SUB;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            status_q   <= ST_NONE;
            ack_q      <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            status_q   <= status_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.o_ack    = ack_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_status = status_q;
    assign bus.o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus randomized traffic,
// per-requester expected-response queues and a cycle-level timing model.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    localparam int M    = 4;
    localparam int MAXV = 1 << M;

    typedef struct {
        int res;
        int st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_op_scheduler_if #(.m(M)) bus ();

    alu_op_scheduler #(.m(M)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    logic [1:0] pend = 2'b00;

    // Timing model state
    int         busy_left = 0;
    int         last_gnt  = 1;
    logic [1:0] exp_ack    = 2'b00;
    logic [1:0] exp_valid  = 2'b00;
    logic [1:0] pend_valid = 2'b00;
    logic       exp_busy   = 1'b0;
    int         held_res   = 0;
    int         held_st    = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference ALU written directly from the arithmetic definitions.
    function automatic exp_t ref_alu(op_t op, int a, int b);
        exp_t e;
        int ones;
        case (op)
            OP_SUB:  e.res = (a - b + MAXV) % MAXV;
            OP_LT:   e.res = (a < b) ? 1 : 0;
            OP_SETB: e.res = a | b;
            default: e.res = (a < MAXV / 2) ? a : (MAXV - (a - MAXV / 2)) % MAXV;
        endcase
        ones = 0;
        for (int i = 0; i < M; i++) ones += (e.res >> i) & 1;
        if (e.res == MAXV - 1)      e.st = 3;
        else if (ones % 2 == 0)     e.st = 2;
        else if (e.res >= MAXV / 2) e.st = 1;
        else                        e.st = 0;
        return e;
    endfunction

    // Timing model: a capture occupies the scheduler for three edges; ties go
    // to the requester not served last; ack follows capture by one cycle and
    // valid by two.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            busy_left  = 0;
            last_gnt   = 1;
            exp_ack    = 2'b00;
            exp_valid  = 2'b00;
            pend_valid = 2'b00;
            exp_busy   = 1'b0;
            held_res   = 0;
            held_st    = 0;
        end else begin
            int w;
            exp_valid  = pend_valid;
            pend_valid = 2'b00;
            exp_ack    = 2'b00;
            if (busy_left > 0) begin
                busy_left--;
            end else if (bus.i_req != 2'b00) begin
                if (bus.i_req == 2'b11) w = (last_gnt == 0) ? 1 : 0;
                else                    w = bus.i_req[1] ? 1 : 0;
                exp_ack[w]    = 1'b1;
                pend_valid[w] = 1'b1;
                last_gnt      = w;
                busy_left     = 2;
            end
            exp_busy = (busy_left != 0);
        end
    end

    // Monitor: compares handshake outputs every cycle and pops the scoreboard
    // on each valid pulse.
    initial forever begin
        @(negedge clk);
        check("ack", int'(bus.o_ack), int'(exp_ack));
        check("valid", int'(bus.o_valid), int'(exp_valid));
        check("busy", int'(bus.o_busy), int'(exp_busy));
        check("ack_valid_overlap", int'((|bus.o_ack) && (|bus.o_valid)), 0);
        if (bus.o_valid == 2'b00) begin
            check("held_result", int'(bus.o_result), held_res);
            check("held_status", int'(bus.o_status), held_st);
        end
        for (int k = 0; k < 2; k++) begin
            if (bus.o_valid[k]) begin
                exp_t e;
                int   sz;
                sz = (k == 0) ? q0.size() : q1.size();
                if (sz == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp%0d_unexpected: got valid with result %0d, expected no response",
                             k, bus.o_result);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("result%0d", k), int'(bus.o_result), e.res);
                    check($sformatf("status%0d", k), int'(bus.o_status), e.st);
                    held_res = e.res;
                    held_st  = e.st;
                end
            end
        end
    end

    task automatic drive_op(input int k, input op_t op, input int a, input int b);
        exp_t e;
        e = ref_alu(op, a, b);
        if (k == 0) begin
            bus.i_op0   = op;
            bus.i_argA0 = a[M-1:0];
            bus.i_argB0 = b[M-1:0];
            q0.push_back(e);
        end else begin
            bus.i_op1   = op;
            bus.i_argA1 = a[M-1:0];
            bus.i_argB1 = b[M-1:0];
            q1.push_back(e);
        end
        cur[k]         = e;
        bus.i_req[k]   = 1'b1;
        pend[k]        = 1'b1;
        $display("issue req%0d op=%0d A=%0d B=%0d -> expect result=%0d status=%0d",
                 k, op, a, b, e.res, e.st);
    endtask

    task automatic drive_rand(input int k);
        drive_op(k, op_t'($urandom_range(3, 0)), $urandom_range(MAXV - 1, 0),
                 $urandom_range(MAXV - 1, 0));
    endtask

    task automatic withdraw(input int k);
        bus.i_req[k] = 1'b0;
        pend[k]      = 1'b0;
        if (k == 0) void'(q0.pop_back());
        else        void'(q1.pop_back());
        $display("withdraw req%0d", k);
    endtask

    // One cycle: inputs change just after the falling edge; an acked request
    // is dropped by default and the caller may reissue it.
    task automatic step(output logic [1:0] got);
        @(negedge clk);
        #1;
        got       = bus.o_ack & pend;
        pend      = pend & ~got;
        bus.i_req = bus.i_req & ~got;
    endtask

    task automatic idle(input int n);
        logic [1:0] g;
        for (int i = 0; i < n; i++) step(g);
    endtask

    task automatic wait_free(input int maxc);
        logic [1:0] g;
        int c;
        c = 0;
        while (pend != 2'b00 && c < maxc) begin
            step(g);
            c++;
        end
        if (pend != 2'b00) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_free_timeout: pending=%b after %0d cycles, expected none", pend, maxc);
            pend = 2'b00;
            bus.i_req = 2'b00;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_ack", int'(bus.o_ack), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_result", int'(bus.o_result), 0);
        check("rst_status", int'(bus.o_status), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        q0.delete();
        q1.delete();
        if (pend[0]) q0.push_back(cur[0]);
        if (pend[1]) q1.push_back(cur[1]);
        @(negedge clk);
        #1;
        rst = 1'b0;
        $display("reset pulse done, pending=%b", pend);
    endtask

    task automatic run_one(input int k, input op_t op, input int a, input int b);
        logic [1:0] g;
        int waited;
        drive_op(k, op, a, b);
        waited = 0;
        g = 2'b00;
        while (!g[k] && waited < 10) begin
            step(g);
            waited++;
        end
        check($sformatf("ack_latency%0d", k), waited, 1);
        idle(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] got;
        int order[$];
        int ack_cyc[$];
        int cnt[2];

        bus.i_req   = 2'b00;
        bus.i_op0   = OP_SUB;
        bus.i_op1   = OP_SUB;
        bus.i_argA0 = '0;
        bus.i_argB0 = '0;
        bus.i_argA1 = '0;
        bus.i_argB1 = '0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", int'(bus.o_busy), 0);
        check("reset_result", int'(bus.o_result), 0);
        rst = 1'b0;

        // Directed operations
        run_one(0, OP_SUB, 3, 5);
        run_one(1, OP_LT, 2, 7);
        run_one(1, OP_LT, 7, 2);
        run_one(0, OP_CONV, 11, 0);
        run_one(1, OP_CONV, 8, 0);
        run_one(0, OP_CONV, 6, 0);
        run_one(1, OP_SETB, 5, 10);
        idle(3);
        check("setb_held_result", int'(bus.o_result), 15);
        check("setb_held_status", int'(bus.o_status), 3);

        // Both requesters back-to-back after reset
        pulse_reset();
        cnt[0] = 0;
        cnt[1] = 0;
        drive_rand(0);
        drive_rand(1);
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            step(got);
            for (int k = 0; k < 2; k++) begin
                if (got[k]) begin
                    order.push_back(k);
                    ack_cyc.push_back(c);
                    cnt[k]++;
                    $display("grant req%0d at cycle %0d", k, c);
                    if (cnt[k] < 2) drive_rand(k);
                end
            end
        end
        check("rr_grants", order.size(), 4);
        foreach (order[i]) check($sformatf("rr_order%0d", i), order[i], i % 2);
        for (int i = 1; i < ack_cyc.size(); i++)
            check($sformatf("ack_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        wait_free(20);
        idle(4);

        // Reset during EXEC with a tie pending afterwards
        drive_op(0, OP_SUB, 9, 1);
        got = 2'b00;
        for (int c = 0; c < 10 && !got[0]; c++) step(got);
        check("exec_ack0", int'(got), 1);
        drive_op(0, OP_SETB, 3, 4);
        drive_op(1, OP_LT, 1, 2);
        pulse_reset();
        step(got);
        check("post_reset_grant", int'(got), 1);
        wait_free(20);
        idle(4);

        // Randomized traffic with withdrawals and occasional resets
        for (int c = 0; c < 400; c++) begin
            step(got);
            for (int k = 0; k < 2; k++) begin
                if (got[k]) begin
                    if ($urandom_range(1, 0) == 1) drive_rand(k);
                end else if (pend[k]) begin
                    if ($urandom_range(19, 0) == 0) withdraw(k);
                end else if ($urandom_range(2, 0) == 0) begin
                    drive_rand(k);
                end
            end
            if ($urandom_range(99, 0) == 0) pulse_reset();
        end
        wait_free(60);
        idle(5);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
